// File: rtl/ls138_scan_pkg.sv
// Shared constants for the 74LS138 scan sequencer: mode codes and direction encoding.
// No logic, no latency.
// No flow control.
package ls138_scan_pkg;

  localparam logic [1:0] MODE_UP       = 2'b00;
  localparam logic [1:0] MODE_DOWN     = 2'b01;
  localparam logic [1:0] MODE_PINGPONG = 2'b10;
  localparam logic [1:0] MODE_HOLD     = 2'b11;

  // Direction of travel; only meaningful in ping-pong, but kept across mode changes.
  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

endpackage

// File: rtl/ls138_scan_prescaler.sv
// Prescaler: counts enabled cycles 0..PRESCALE-1 and flags the last one.
// Strobe is combinational in the cycle the count sits at PRESCALE-1 with en high.
// en low freezes the count; clear returns it to 0 on the next edge.
module scan_prescaler #(
  parameter int unsigned PRESCALE = 50000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic clear_i,
  output logic strobe_o
);

  localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign strobe_o = en_i & (cnt_q == LAST);

  // Next count: clear wins, otherwise advance/wrap only on enabled cycles.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = strobe_o ? '0 : cnt_q + CW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/ls138_scan_ctrl.sv
// Drives A2..A0 and G1/G2A/G2B of a 3-to-8 decoder, stepping the select at a prescaled rate.
// All outputs registered; a step appears one edge after the prescaler strobe.
// No backpressure; LOAD overrides a same-cycle step, BLANK/EN only gate G1.
module ls138_scan_ctrl
  import ls138_scan_pkg::*;
#(
  parameter int unsigned PRESCALE = 50000,
  parameter int unsigned DEAD     = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic       blank_i,
  input  logic [1:0] mode_i,
  input  logic       load_i,
  input  logic [2:0] load_addr_i,
  output logic       a2_o,
  output logic       a1_o,
  output logic       a0_o,
  output logic       g1_o,
  output logic       g2a_o,
  output logic       g2b_o,
  output logic       tick_o,
  output logic       wrap_o
);

  // Illegal parameter combinations stop elaboration.
  if (PRESCALE < 1 || PRESCALE > 65535) begin : g_prescale_chk
    $error("ls138_scan_ctrl: PRESCALE must be within 1..65535");
  end
  if (DEAD >= PRESCALE) begin : g_dead_chk
    $error("ls138_scan_ctrl: DEAD must be less than PRESCALE");
  end

  logic        strobe;
  logic [2:0]  addr_q, addr_d;
  dir_e        dir_q, dir_d;
  logic [15:0] dead_q, dead_d;
  logic        g1_q, g1_d;
  logic        tick_q, tick_d;
  logic        wrap_q, wrap_d;
  logic        addr_chg;

  // Load restarts the step interval so the loaded address is shown for a full period.
  scan_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .en_i     (en_i),
    .clear_i  (load_i),
    .strobe_o (strobe)
  );

  // Next address/direction, tick/wrap pulses and dead-window reload.
  always_comb begin
    addr_d   = addr_q;
    dir_d    = dir_q;
    tick_d   = 1'b0;
    wrap_d   = 1'b0;
    addr_chg = 1'b0;
    if (load_i) begin
      addr_d   = load_addr_i;
      dir_d    = DIR_UP;
      addr_chg = 1'b1;
    end else if (strobe) begin
      tick_d = 1'b1;
      case (mode_i)
        MODE_UP: begin
          addr_d   = addr_q + 3'd1;
          wrap_d   = (addr_q == 3'd7);
          addr_chg = 1'b1;
        end
        MODE_DOWN: begin
          addr_d   = addr_q - 3'd1;
          wrap_d   = (addr_q == 3'd0);
          addr_chg = 1'b1;
        end
        MODE_PINGPONG: begin
          addr_chg = 1'b1;
          if (dir_q == DIR_UP) begin
            if (addr_q == 3'd7) begin
              addr_d = 3'd6;
              dir_d  = DIR_DOWN;
            end else begin
              addr_d = addr_q + 3'd1;
            end
          end else begin
            if (addr_q == 3'd0) begin
              addr_d = 3'd1;
              dir_d  = DIR_UP;
              wrap_d = 1'b1;
            end else begin
              addr_d = addr_q - 3'd1;
            end
          end
        end
        default: ;  // hold: tick only, address and dead window untouched
      endcase
    end

    if (addr_chg)              dead_d = 16'(DEAD);
    else if (dead_q != 16'd0)  dead_d = dead_q - 16'd1;
    else                       dead_d = dead_q;

    g1_d = en_i & ~blank_i & (dead_d == 16'd0);
  end

  // Sequencer state and registered decoder controls.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q <= 3'd0;
      dir_q  <= DIR_UP;
      dead_q <= 16'd0;
      g1_q   <= 1'b0;
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      addr_q <= addr_d;
      dir_q  <= dir_d;
      dead_q <= dead_d;
      g1_q   <= g1_d;
      tick_q <= tick_d;
      wrap_q <= wrap_d;
    end
  end

  assign a2_o   = addr_q[2];
  assign a1_o   = addr_q[1];
  assign a0_o   = addr_q[0];
  assign g1_o   = g1_q;
  assign g2a_o  = ~g1_q;
  assign g2b_o  = ~g1_q;
  assign tick_o = tick_q;
  assign wrap_o = wrap_q;

endmodule

// File: tb/tb_ls138_scan_ctrl.sv
module tb_ls138_scan_ctrl;

  localparam int PS = 4;
  localparam int DT = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       blank = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       load = 1'b0;
  logic [2:0] load_addr = 3'd0;
  logic       a2, a1, a0, g1, g2a, g2b, tick, wrap;

  int total = 0;
  int bad = 0;

  // Behavioural reference state (plain integers)
  int m_cnt, m_addr, m_dir, m_dead, m_g1, m_tick, m_wrap;
  int seq[10];

  always #5 clk = ~clk;

  ls138_scan_ctrl #(.PRESCALE(PS), .DEAD(DT)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .en_i        (en),
    .blank_i     (blank),
    .mode_i      (mode),
    .load_i      (load),
    .load_addr_i (load_addr),
    .a2_o        (a2),
    .a1_o        (a1),
    .a0_o        (a0),
    .g1_o        (g1),
    .g2a_o       (g2a),
    .g2b_o       (g2b),
    .tick_o      (tick),
    .wrap_o      (wrap)
  );

  function automatic int addr_now();
    return int'({a2, a1, a0});
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_addr = 0; m_dir = 0; m_dead = 0;
    m_g1 = 0; m_tick = 0; m_wrap = 0;
  endtask

  // One clock edge of the reference, evaluated from the current inputs.
  task automatic model_edge();
    bit changed;
    bit stb;
    changed = 0;
    m_tick = 0;
    m_wrap = 0;
    if (load) begin
      m_addr = int'(load_addr);
      m_cnt = 0;
      m_dir = 0;
      changed = 1;
    end else begin
      stb = en && (m_cnt == PS - 1);
      if (en) m_cnt = stb ? 0 : m_cnt + 1;
      if (stb) begin
        m_tick = 1;
        case (int'(mode))
          0: begin m_wrap = (m_addr == 7); m_addr = (m_addr + 1) % 8; changed = 1; end
          1: begin m_wrap = (m_addr == 0); m_addr = (m_addr + 7) % 8; changed = 1; end
          2: begin
            changed = 1;
            if (m_dir == 0) begin
              if (m_addr == 7) begin m_addr = 6; m_dir = 1; end
              else m_addr = m_addr + 1;
            end else begin
              if (m_addr == 0) begin m_addr = 1; m_dir = 0; m_wrap = 1; end
              else m_addr = m_addr - 1;
            end
          end
          default: ;
        endcase
      end
    end
    if (changed) m_dead = DT;
    else if (m_dead > 0) m_dead = m_dead - 1;
    m_g1 = (en && !blank && m_dead == 0) ? 1 : 0;
  endtask

  task automatic check_outs(input string tag);
    chk({tag, ".addr"}, addr_now(), m_addr);
    chk({tag, ".g1"}, int'(g1), m_g1);
    chk({tag, ".g2a"}, int'(g2a), 1 - m_g1);
    chk({tag, ".g2b"}, int'(g2b), 1 - m_g1);
    chk({tag, ".tick"}, int'(tick), m_tick);
    chk({tag, ".wrap"}, int'(wrap), m_wrap);
  endtask

  // Called at a falling edge with inputs already set; returns at the next falling edge.
  task automatic cyc(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_outs(tag);
    @(negedge clk);
  endtask

  task automatic do_load(input int a);
    load = 1'b1;
    load_addr = 3'(a);
    cyc("load");
    load = 1'b0;
  endtask

  // Load a start address, then expect one step per PS cycles following seq[].
  task automatic run_seq(input string tag, input logic [1:0] md, input int start,
                         input int n, input int wrap_idx);
    mode = md;
    do_load(start);
    for (int i = 0; i < n; i++) begin
      repeat (PS) cyc(tag);
      chk({tag, ".seq"}, addr_now(), seq[i]);
      chk({tag, ".wrapflag"}, int'(wrap), (i == wrap_idx) ? 1 : 0);
    end
  endtask

  initial begin
    int guard;
    model_reset();
    #1;
    check_outs("reset");
    chk("reset.g2a_hi", int'(g2a), 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // First step after PS enabled cycles, dead window of one cycle
    en = 1'b1;
    mode = 2'b00;
    repeat (3) cyc("first");
    chk("first.addr_before", addr_now(), 0);
    chk("first.g1_before", int'(g1), 1);
    cyc("first");
    chk("first.addr_step", addr_now(), 1);
    chk("first.tick", int'(tick), 1);
    chk("first.g1_dead", int'(g1), 0);
    cyc("first");
    chk("first.g1_after", int'(g1), 1);

    // Up from 6, down from 1, ping-pong from 5
    seq[0] = 7; seq[1] = 0;
    run_seq("up", 2'b00, 6, 2, 1);
    seq[0] = 0; seq[1] = 7;
    run_seq("down", 2'b01, 1, 2, 1);
    seq = '{6, 7, 6, 5, 4, 3, 2, 1, 0, 1};
    run_seq("pp", 2'b10, 5, 10, 9);

    // LOAD coinciding with a strobe
    mode = 2'b00;
    guard = 0;
    while (m_cnt != PS - 1 && guard < 20) begin cyc("align"); guard++; end
    chk("ldstb.aligned", m_cnt, PS - 1);
    do_load(5);
    chk("ldstb.addr", addr_now(), 5);
    chk("ldstb.tick", int'(tick), 0);
    chk("ldstb.g1", int'(g1), 0);
    repeat (3) cyc("ldstb");
    chk("ldstb.hold", addr_now(), 5);
    cyc("ldstb");
    chk("ldstb.next", addr_now(), 6);

    // EN low for 3 cycles mid-count delays the step by 3
    do_load(2);
    repeat (2) cyc("engap");
    en = 1'b0;
    cyc("engap");
    chk("engap.g1_drop", int'(g1), 0);
    repeat (2) cyc("engap");
    en = 1'b1;
    cyc("engap");
    chk("engap.not_yet", addr_now(), 2);
    cyc("engap");
    chk("engap.step", addr_now(), 3);

    // BLANK across a step: address advances, G1 stays low
    blank = 1'b1;
    repeat (PS + 1) cyc("blank");
    chk("blank.addr", addr_now(), 4);
    chk("blank.g1", int'(g1), 0);
    blank = 1'b0;

    // Async reset mid dead-window and mid-count
    do_load(3);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_outs("arst");
    @(negedge clk);
    rst_n = 1'b1;
    mode = 2'b00;
    repeat (PS - 1) cyc("post_rst");
    chk("post_rst.addr0", addr_now(), 0);
    cyc("post_rst");
    chk("post_rst.addr1", addr_now(), 1);

    // Randomised operation against the reference
    for (int i = 0; i < 600; i++) begin
      en = ($urandom_range(0, 9) != 0);
      blank = ($urandom_range(0, 14) == 0);
      load = ($urandom_range(0, 24) == 0);
      load_addr = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
      cyc("rand");
    end
    load = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
